// File: rtl/ife_block_dispatch.sv
// ---------------------------------------------------------------------------
// ife_block_dispatch
//   Accepts a block of BLOCK_SIZE instructions and issues them one beat at a
//   time, lowest pending slot first. When SKIP_NOP is set, NOP slots are
//   dropped. A block made only of NOPs still issues one beat (its last slot),
//   so every block ends with exactly one instr_last beat. The last beat of a
//   block and the next block's acceptance can share a cycle, so consecutive
//   blocks issue with no bubble between them.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   block_id_in     id of the offered block
//   block_in        offered instructions, slot 0 in the least-significant lane
//   valid_in        offered block is valid
//   ready_in        block accepted this cycle when valid_in is also high
//   instr_out       issued instruction
//   instr_block_id  id of the block that owns instr_out
//   instr_slot      slot index of instr_out within its block
//   instr_last      instr_out is the final beat of its block
//   valid_out       instruction beat valid
//   ready_out       downstream accepts the beat
//   flush           discard the block in flight (synchronous)
//   blocks_done     count of blocks fully dispatched, wraps at 2^16
//
// state | meaning
// IDLE  | no block held, ready for a new one
// ISSUE | block held, at least one pending slot left to issue
// ---------------------------------------------------------------------------
module ife_block_dispatch #(
    parameter int                     BLOCK_ID_WIDTH = 8,
    parameter int                     INSTR_WIDTH    = 32,
    parameter int                     BLOCK_SIZE     = 4,
    parameter int                     SKIP_NOP       = 1,
    parameter logic [INSTR_WIDTH-1:0] NOP_ENCODING   = INSTR_WIDTH'(32'h0000_0013),
    localparam int                    SLOT_W         = $clog2(BLOCK_SIZE)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [BLOCK_ID_WIDTH-1:0]              block_id_in,
    input  logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] block_in,
    input  logic                                   valid_in,
    output logic                                   ready_in,
    output logic [INSTR_WIDTH-1:0]                 instr_out,
    output logic [BLOCK_ID_WIDTH-1:0]              instr_block_id,
    output logic [SLOT_W-1:0]                      instr_slot,
    output logic                                   instr_last,
    output logic                                   valid_out,
    input  logic                                   ready_out,
    input  logic                                   flush,
    output logic [15:0]                            blocks_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                                 state_q, state_d;
    logic [BLOCK_SIZE-1:0][INSTR_WIDTH-1:0] block_q, block_d;
    logic [BLOCK_ID_WIDTH-1:0]              id_q, id_d;
    logic [BLOCK_SIZE-1:0]                  pending_q, pending_d;
    logic [15:0]                            done_q, done_d;

    logic [BLOCK_SIZE-1:0] load_mask;
    logic [BLOCK_SIZE-1:0] slot_onehot;
    logic [SLOT_W-1:0]     slot;
    logic                  single;
    logic                  xfer_in;
    logic                  xfer_out;

    // Pending mask for the offered block; an all-NOP block falls back to its
    // last slot so it still produces a terminating beat.
    always_comb begin
        load_mask = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            load_mask[i] = (SKIP_NOP == 0) || (block_in[i] != NOP_ENCODING);
        end
        if (load_mask == '0) begin
            load_mask[BLOCK_SIZE-1] = 1'b1;
        end
    end

    // Lowest set pending bit selects the slot to issue.
    always_comb begin
        slot = '0;
        for (int i = BLOCK_SIZE - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                slot = SLOT_W'(i);
            end
        end
        slot_onehot       = '0;
        slot_onehot[slot] = 1'b1;
    end

    assign single = (pending_q != '0) &&
                    ((pending_q & (pending_q - BLOCK_SIZE'(1))) == '0);

    assign valid_out      = (state_q == ISSUE);
    assign instr_out      = block_q[slot];
    assign instr_block_id = id_q;
    assign instr_slot     = slot;
    assign instr_last     = valid_out && single;
    assign blocks_done    = done_q;

    assign xfer_out = valid_out && ready_out;
    assign ready_in = ((state_q == IDLE) || (xfer_out && instr_last)) && !flush;
    assign xfer_in  = valid_in && ready_in;

    always_comb begin
        state_d   = state_q;
        block_d   = block_q;
        id_d      = id_q;
        pending_d = pending_q;
        done_d    = done_q;
        if (flush) begin
            state_d   = IDLE;
            pending_d = '0;
        end else begin
            if (xfer_out) begin
                pending_d = pending_q & ~slot_onehot;
                if (instr_last) begin
                    done_d  = done_q + 16'd1;
                    state_d = IDLE;
                end
            end
            // Loading after the issue update lets a new block replace a
            // finishing one in the same cycle.
            if (xfer_in) begin
                block_d   = block_in;
                id_d      = block_id_in;
                pending_d = load_mask;
                state_d   = ISSUE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            block_q   <= '0;
            id_q      <= '0;
            pending_q <= '0;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            block_q   <= block_d;
            id_q      <= id_d;
            pending_q <= pending_d;
            done_q    <= done_d;
        end
    end

endmodule
